ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the send direction of the PS/2 link whose receive side is the existing keyboard interface.
- Sends one command byte per request to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Runs the PS/2 request-to-send sequence: inhibit, start, 8 data bits, odd parity, stop, device ACK.
- Drives ps2_clock/ps2_data as open-drain through drive-low enables; the top level does the tri-state (line = oe ? 0 : Z).

Parameters:
- INHIBIT_CYCLES, 5000, clock cycles ps2_clock is held low before start (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, watchdog limit between device clock falling edges (15 ms at 50 MHz).
- SYNC_STAGES, 2, synchronizer depth on ps2_clk_in/ps2_dat_in (minimum 2).

Ports:
- clock  input  1  system clock (50 MHz)
- resetn  input  1  asynchronous active-low reset
- tx_data  input  8  byte to send
- tx_valid  input  1  request; accepted when tx_valid && tx_ready
- tx_ready  output  1  high only in IDLE
- busy  output  1  high in any state other than IDLE; the receiver uses it to ignore bus activity
- tx_done  output  1  one-cycle pulse: frame sent and ACK received
- tx_error  output  1  one-cycle pulse: timeout or missing ACK
- ps2_clk_in  input  1  raw ps2_clock line level
- ps2_dat_in  input  1  raw ps2_data line level
- ps2_clk_oe  output  1  1 = pull ps2_clock low
- ps2_dat_oe  output  1  1 = pull ps2_data low

Behaviour:
- Reset (async, resetn=0): state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, tx_ready=1, busy=0; counters and shift register cleared.
  - Reset asserted mid-frame releases both lines immediately, without waiting for a clock edge.
- Inputs: SYNC_STAGES-flop synchronizers. fall = previous synced clk 1 && current synced clk 0.
- Accept in IDLE:
  - Latch frame[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data}; bit_idx=0; cnt=0.
  - Go to INHIBIT. tx_valid outside IDLE is ignored, not queued.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_dat_oe=1 (start bit 0) during the final INHIBIT cycle.
  - Next state SEND.
- SEND:
  - ps2_clk_oe=0 (clock released to the device); ps2_dat_oe keeps the current bit.
  - On each fall: ps2_dat_oe = ~frame[bit_idx]; bit_idx++. Bits go out LSB first, then parity, then stop.
  - Stop bit = data released (oe=0).
  - After the 10th fall (stop driven), go to ACK.
- ACK:
  - Both oe=0.
  - On the next fall (11th), sample synced data:
    - data 0: go to RELEASE.
    - data 1: pulse tx_error, go to IDLE.
- RELEASE: wait until synced clk=1 and synced data=1, then pulse tx_done and go to IDLE.
- Watchdog:
  - Counter runs in SEND, ACK and RELEASE; cleared on every fall and on entry to SEND.
  - Reaching TIMEOUT_CYCLES: both oe=0, pulse tx_error, go to IDLE.
- tx_done and tx_error are mutually exclusive and never both high in the same cycle.
- tx_ready rises in the cycle after the done/error pulse, so the earliest next acceptance is that cycle.
- Only one fall is consumed per cycle; a fall is only detected by the synchronized edge logic.
- Latency: fall on the line to oe update = SYNC_STAGES+1 cycles. This is negligible against the 10–16.7 kHz device clock.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and samples on rising edges:
  - ps2_clk_oe high for 5000 cycles; ps2_dat_oe high in its last cycle.
  - Device samples start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Model ACKs low → single tx_done pulse, tx_error never high, tx_ready=1 afterwards.
- Parity sweep: 0x00 → parity 1; 0xFF → parity 1; 0x01 → parity 0; 0x80 → parity 0. The device model checks each.
- No device (clk line stays high after inhibit): after TIMEOUT_CYCLES, tx_error pulses once, both oe=0, state back to IDLE.
- Missing ACK (model leaves data high on the 11th clock): tx_error pulses, no tx_done.
- resetn pulled low after the 4th data bit: ps2_clk_oe=ps2_dat_oe=0 in the same cycle; after release tx_ready=1, and a new send of 0xF4 completes correctly.
- tx_valid held high with a different byte during a frame: the in-flight frame is unchanged, and the second byte is accepted only after tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits with odd
// parity, stop and device ACK. Both lines are driven open-drain through drive-low enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                          : INHIBIT_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned FRAME_W  = 10;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = FRAME_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 dat_oe_q, dat_oe_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s_c;
    logic                   dat_s_c;
    logic                   fall_c;
    logic                   timeout_c;

    // Line synchronizers; idle level of both lines is high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s_c   = clk_sync_q[SYNC_STAGES-1];
    assign dat_s_c   = dat_sync_q[SYNC_STAGES-1];
    assign fall_c    = clk_prev_q && !clk_s_c;
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    bit_idx_d = '0;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    dat_oe_d  = (INHIBIT_CYCLES <= 1);
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Start bit goes low during the final inhibit cycle.
                    if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) begin
                        dat_oe_d = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (fall_c) begin
                    dat_oe_d  = ~frame_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    cnt_d     = '0;
                    if (bit_idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = S_ACK;
                    end
                end else if (timeout_c) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ACK: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (fall_c) begin
                    cnt_d = '0;
                    if (!dat_s_c) begin
                        state_d = S_RELEASE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (timeout_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RELEASE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (clk_s_c && dat_s_c) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (fall_c) begin
                    cnt_d = '0;
                end else if (timeout_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        // Ready returns one cycle after a done/error pulse.
        ready_d = (state_d == S_IDLE) && !done_d && !error_d;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule
